// File: rtl/instr_fetcher.sv
// Instruction fetch unit: one outstanding memory read, branch
// prediction handshake and a circular fetch queue toward decode.
module instr_fetcher #(
  parameter int QUEUE_DEPTH = 4
) (
  input  logic        clk_in,
  input  logic        rst_in,
  input  logic        rdy_in,
  output logic        mem_req_valid_to_mc,
  output logic [31:0] mem_req_addr_to_mc,
  input  logic        mem_resp_valid_from_mc,
  input  logic [31:0] mem_resp_inst_from_mc,
  output logic        enable_to_predictor,
  output logic [31:0] pc_to_predictor,
  input  logic        end_from_predictor,
  input  logic [31:0] address_from_predictor,
  input  logic        jump_predict_flag_from_predictor,
  output logic        inst_valid_to_decoder,
  output logic [31:0] inst_to_decoder,
  output logic [31:0] pc_to_decoder,
  output logic        jump_flag_to_decoder,
  input  logic        pop_from_decoder,
  input  logic        rollback_flag_from_rob,
  input  logic [31:0] rollback_pc_from_rob
);

  localparam int AW = $clog2(QUEUE_DEPTH);
  localparam int CW = $clog2(QUEUE_DEPTH) + 1;

  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;

  typedef enum logic [1:0] {
    IDLE,
    WAIT_MEM,
    WAIT_PRED,
    DISCARD
  } state_t;

  state_t state, state_nx;

  logic [31:0] pc, pc_nx;
  logic [31:0] br_inst, br_inst_nx;

  logic [31:0] q_inst [QUEUE_DEPTH];
  logic [31:0] q_pc   [QUEUE_DEPTH];
  logic        q_flag [QUEUE_DEPTH];

  logic [AW-1:0] head, tail;
  logic [CW-1:0] count;

  logic        full;
  logic        push;
  logic [31:0] push_inst;
  logic        push_flag;
  logic        clear;
  logic        pop_en;
  logic [6:0]  opcode;
  logic [31:0] jal_imm;

  assign full   = (count == CW'(QUEUE_DEPTH));
  assign opcode = mem_resp_inst_from_mc[6:0];
  assign jal_imm = {{11{mem_resp_inst_from_mc[31]}},
                    mem_resp_inst_from_mc[31],
                    mem_resp_inst_from_mc[19:12],
                    mem_resp_inst_from_mc[20],
                    mem_resp_inst_from_mc[30:21],
                    1'b0};

  always_comb begin
    state_nx   = state;
    pc_nx      = pc;
    br_inst_nx = br_inst;
    push       = 1'b0;
    push_inst  = mem_resp_inst_from_mc;
    push_flag  = 1'b0;
    clear      = 1'b0;
    unique case (state)
      IDLE: begin
        if (!full) state_nx = WAIT_MEM;
      end
      WAIT_MEM: begin
        if (mem_resp_valid_from_mc) begin
          unique case (1'b1)
            (opcode == OP_BRANCH): begin
              br_inst_nx = mem_resp_inst_from_mc;
              state_nx   = WAIT_PRED;
            end
            (opcode == OP_JAL): begin
              push      = 1'b1;
              push_flag = 1'b1;
              pc_nx     = pc + jal_imm;
              state_nx  = IDLE;
            end
            default: begin
              push     = 1'b1;
              pc_nx    = pc + 32'd4;
              state_nx = IDLE;
            end
          endcase
        end
      end
      WAIT_PRED: begin
        if (end_from_predictor) begin
          push      = 1'b1;
          push_inst = br_inst;
          push_flag = jump_predict_flag_from_predictor;
          pc_nx     = jump_predict_flag_from_predictor ?
                      address_from_predictor : pc + 32'd4;
          state_nx  = IDLE;
        end
      end
      DISCARD: begin
        if (mem_resp_valid_from_mc) state_nx = IDLE;
      end
    endcase
    // DISCARD still owes the memory one response, so only retarget PC
    if (rollback_flag_from_rob) begin
      pc_nx = rollback_pc_from_rob;
      if (state != DISCARD) begin
        clear      = 1'b1;
        push       = 1'b0;
        br_inst_nx = br_inst;
        state_nx   = (state == WAIT_MEM && !mem_resp_valid_from_mc) ?
                     DISCARD : IDLE;
      end
    end
  end

  assign pop_en = pop_from_decoder && (count != '0) && !clear;

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state   <= IDLE;
      pc      <= '0;
      br_inst <= '0;
      head    <= '0;
      tail    <= '0;
      count   <= '0;
    end else if (rdy_in) begin
      state   <= state_nx;
      pc      <= pc_nx;
      br_inst <= br_inst_nx;
      if (clear) begin
        head  <= '0;
        tail  <= '0;
        count <= '0;
      end else begin
        if (push) begin
          q_inst[tail] <= push_inst;
          q_pc[tail]   <= pc;
          q_flag[tail] <= push_flag;
          tail         <= tail + AW'(1);
        end
        if (pop_en) head <= head + AW'(1);
        count <= count + CW'(push) - CW'(pop_en);
      end
    end
  end

  assign mem_req_valid_to_mc   = (state == WAIT_MEM);
  assign mem_req_addr_to_mc    = mem_req_valid_to_mc ? pc : '0;
  assign enable_to_predictor   = (state == WAIT_PRED);
  assign pc_to_predictor       = enable_to_predictor ? pc : '0;
  assign inst_valid_to_decoder = (count != '0);
  assign inst_to_decoder       = inst_valid_to_decoder ? q_inst[head] : '0;
  assign pc_to_decoder         = inst_valid_to_decoder ? q_pc[head] : '0;
  assign jump_flag_to_decoder  = inst_valid_to_decoder && q_flag[head];

endmodule

// File: doc/instr_fetcher.md
INSTR_FETCHER -- requirements
Module: instr_fetcher

Interface
REQ-001 Parameter QUEUE_DEPTH, default 4, power of two, entries in the fetch queue.
REQ-002 Ports (clock and reset first):
  clk_in  in  1  single clock, all logic on rising edge
  rst_in  in  1  synchronous, active-high reset
  rdy_in  in  1  global enable; low = hold all state
  mem_req_valid_to_mc  out  1  instruction read request
  mem_req_addr_to_mc  out  32  word address of request
  mem_resp_valid_from_mc  in  1  one-cycle pulse, instruction returned
  mem_resp_inst_from_mc  in  32  returned instruction
  enable_to_predictor  out  1  prediction request
  pc_to_predictor  out  32  PC of the branch under prediction
  end_from_predictor  in  1  one-cycle pulse, prediction ready
  address_from_predictor  in  32  predicted target
  jump_predict_flag_from_predictor  in  1  1 = predicted taken
  inst_valid_to_decoder  out  1  queue head valid
  inst_to_decoder  out  32  head instruction
  pc_to_decoder  out  32  head PC
  jump_flag_to_decoder  out  1  head predicted-taken flag
  pop_from_decoder  in  1  consume head this cycle
  rollback_flag_from_rob  in  1  flush, redirect fetch
  rollback_pc_from_rob  in  32  redirect target

Function
REQ-003 With rdy_in low, the block SHALL hold all registers and outputs; rst_in and rollback are ignored unless rdy_in is high, except that rst_in SHALL take effect regardless of rdy_in.
REQ-004 FSM states SHALL be IDLE, WAIT_MEM, WAIT_PRED, DISCARD.
REQ-005 IDLE: if queue not full, assert mem_req_valid_to_mc with mem_req_addr_to_mc = fetch PC, go WAIT_MEM; if full, stay IDLE with no request.
REQ-006 WAIT_MEM: hold request and address stable until mem_resp_valid_from_mc; drop mem_req_valid_to_mc the cycle after the response.
REQ-007 On response, decode opcode inst[6:0]: 1100011 (branch) -> go WAIT_PRED; 1101111 (JAL) -> push {inst, pc, flag=1}, PC <= pc + sign-extended J-immediate (mod 2^32); otherwise -> push {inst, pc, flag=0}, PC <= pc + 4 (wraps at 2^32); then IDLE.
REQ-008 WAIT_PRED: assert enable_to_predictor with pc_to_predictor = branch PC until end_from_predictor; then push {inst, pc, jump_predict_flag_from_predictor}, PC <= flag ? address_from_predictor : pc + 4, go IDLE.
REQ-009 Queue: circular, head/tail pointers plus count; push at tail, pop at head when pop_from_decoder and inst_valid_to_decoder; simultaneous push and pop SHALL keep count unchanged; pop on empty SHALL be ignored.
REQ-010 inst_valid_to_decoder SHALL equal (count != 0); head data outputs driven from the head entry.
REQ-011 Rollback (highest priority after reset): queue cleared (count 0, pointers 0), PC <= rollback_pc_from_rob, predictor enable dropped, next state IDLE; if state was WAIT_MEM and no response arrives the same cycle, next state is DISCARD instead.
REQ-012 DISCARD: no request, wait for mem_resp_valid_from_mc, drop the response, go IDLE; a further rollback in DISCARD updates PC only.
REQ-013 A response or prediction arriving in the rollback cycle SHALL be dropped, no push.
REQ-014 Latency: non-branch instruction visible at decoder one cycle after its memory response; branch one cycle after end_from_predictor.

Reset
REQ-015 On rst_in: state IDLE, PC 0x00000000, queue empty, pointers 0, all outputs 0.

Verification
REQ-016 Reset then mem responds 0x00000013 after 3 cycles -> request addr 0x0, entry {0x13, pc 0x0, flag 0} valid next cycle, next request addr 0x4.
REQ-017 Branch 0xFE000EE3 at pc 0x10, predictor returns taken, target 0x8 -> pc_to_predictor 0x10, entry flag 1, next request addr 0x8.
REQ-018 JAL 0x0080006F at pc 0x20 -> no predictor request, entry flag 1, next request addr 0x28.
REQ-019 Decoder never pops, QUEUE_DEPTH=4 -> exactly 4 entries pushed, no fifth request; one pop -> exactly one further request.
REQ-020 Rollback to 0x100 during WAIT_MEM -> queue empty next cycle, late response dropped, next request addr 0x100.
REQ-021 rdy_in low for 5 cycles mid-WAIT_PRED -> state, queue, outputs unchanged; resumes correctly when high.
